// File: rtl/tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler slice.
//   state_t          : step-issue FSM states (IDLE=0, STEP=1, WAIT=2)
//   TIMER_W_DEFAULT  : default width of the DT/ST registers
package tick_scheduler_pkg;

  localparam int unsigned TIMER_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/tick_scheduler_countdown_reg.sv
// Load / decrement / saturate-at-zero register used for CHIP-8 DT and ST.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (value -> 0)
//   we         : load wr_data (wins over tick in the same cycle)
//   tick       : decrement request, already qualified by pause
//   wr_data    : load value
//   value      : current register contents
module countdown_reg #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               tick,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (we) begin
      value <= wr_data;
    end else if (tick && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Turns timer pulses into CPU step requests and owns the DT/ST registers.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   timer_cpu_tick    : CPU-rate pulse; each one requests a CPU step
//   timer_60hz_tick   : 60 Hz pulse; decrements DT/ST
//   pause             : blocks new step issues and DT/ST countdown
//   cpu_step/cpu_done : one-cycle start/done handshake with the CPU core
//   dt_we/st_we       : load DT/ST from wr_data
//   dt_value/st_value : current DT/ST
//   sound_on          : buzzer enable, high while ST != 0
//   overrun           : sticky, set when a CPU tick was dropped
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned BACKLOG_MAX = 3,
  parameter int unsigned BACKLOG_W   = 2,
  parameter int unsigned TIMER_W     = TIMER_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timer_cpu_tick,
  input  logic               timer_60hz_tick,
  input  logic               pause,
  output logic               cpu_step,
  input  logic               cpu_done,
  input  logic               dt_we,
  input  logic               st_we,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] dt_value,
  output logic [TIMER_W-1:0] st_value,
  output logic               sound_on,
  output logic               overrun
);

  state_t               state, state_next;
  logic [BACKLOG_W-1:0] backlog;
  logic                 tick_ok;
  logic                 want_step;
  logic                 issue;
  logic                 countdown;

  assign tick_ok   = timer_cpu_tick && !pause;
  assign want_step = !pause && ((backlog != '0) || timer_cpu_tick);
  assign countdown = timer_60hz_tick && !pause;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (want_step) state_next = STEP;
      STEP:    state_next = WAIT;
      WAIT:    if (cpu_done) state_next = want_step ? STEP : IDLE;
      default: state_next = IDLE;
    endcase
    // STEP always moves on to WAIT, so heading to STEP means a new issue.
    issue = (state_next == STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      backlog <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (tick_ok && !issue) begin
        if (backlog == BACKLOG_W'(BACKLOG_MAX)) overrun <= 1'b1;
        else                                    backlog <= backlog + 1'b1;
      end else if (!tick_ok && issue) begin
        backlog <= backlog - 1'b1;
      end
    end
  end

  assign cpu_step = (state == STEP);

  countdown_reg #(.TIMER_W(TIMER_W)) u_dt (
    .clk     (clk),
    .rst     (rst),
    .we      (dt_we),
    .tick    (countdown),
    .wr_data (wr_data),
    .value   (dt_value)
  );

  countdown_reg #(.TIMER_W(TIMER_W)) u_st (
    .clk     (clk),
    .rst     (rst),
    .we      (st_we),
    .tick    (countdown),
    .wr_data (wr_data),
    .value   (st_value)
  );

  assign sound_on = (st_value != '0);

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: a cycle model of the scheduling
// rules checked every cycle, plus directed literal expectations.
module tb_tick_scheduler;
  import tick_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       timer_cpu_tick = 1'b0;
  logic       timer_60hz_tick = 1'b0;
  logic       pause = 1'b0;
  logic       cpu_step;
  logic       cpu_done = 1'b0;
  logic       dt_we = 1'b0;
  logic       st_we = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] dt_value;
  logic [7:0] st_value;
  logic       sound_on;
  logic       overrun;

  always #5 clk = ~clk;

  tick_scheduler #(.BACKLOG_MAX(3), .BACKLOG_W(2), .TIMER_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .timer_cpu_tick  (timer_cpu_tick),
    .timer_60hz_tick (timer_60hz_tick),
    .pause           (pause),
    .cpu_step        (cpu_step),
    .cpu_done        (cpu_done),
    .dt_we           (dt_we),
    .st_we           (st_we),
    .wr_data         (wr_data),
    .dt_value        (dt_value),
    .st_value        (st_value),
    .sound_on        (sound_on),
    .overrun         (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: pending ticks, whether a step pulse is due, whether the CPU is busy.
  int m_backlog = 0;
  bit m_step = 0, m_busy = 0, m_ovr = 0, m_valid = 0;
  int m_dt = 0, m_st = 0;

  always @(posedge clk) begin
    bit free, tk, iss;
    if (rst) begin
      m_backlog = 0; m_step = 0; m_busy = 0; m_ovr = 0;
      m_dt = 0; m_st = 0; m_valid = 1;
    end else begin
      free = (!m_step && !m_busy) || (m_busy && cpu_done);
      tk   = timer_cpu_tick && !pause;
      iss  = free && !pause && (m_backlog > 0 || timer_cpu_tick);
      if (tk && !iss) begin
        if (m_backlog == 3) m_ovr = 1;
        else                m_backlog++;
      end else if (!tk && iss) begin
        m_backlog--;
      end
      m_busy = m_step || (m_busy && !cpu_done);
      m_step = iss;
      if (dt_we) m_dt = wr_data;
      else if (timer_60hz_tick && !pause && m_dt > 0) m_dt--;
      if (st_we) m_st = wr_data;
      else if (timer_60hz_tick && !pause && m_st > 0) m_st--;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_cpu_step", cpu_step, m_step);
      chk("m_dt", dt_value, m_dt);
      chk("m_st", st_value, m_st);
      chk("m_sound", sound_on, m_st != 0);
      chk("m_overrun", overrun, m_ovr);
      chk("m_backlog", dut.backlog, m_backlog);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_tick();
    timer_cpu_tick = 1'b1; cyc(1); timer_cpu_tick = 1'b0;
  endtask

  task automatic hz_tick();
    timer_60hz_tick = 1'b1; cyc(1); timer_60hz_tick = 1'b0;
  endtask

  task automatic done_pulse();
    cpu_done = 1'b1; cyc(1); cpu_done = 1'b0;
  endtask

  initial begin
    // 1: single tick, done three cycles after the step
    cyc(2);
    rst = 1'b0;
    chk("t1_rst_step", cpu_step, 0);
    chk("t1_rst_ovr", overrun, 0);
    chk("t1_rst_state", int'(dut.state), int'(IDLE));
    cyc(4);
    cpu_tick();
    chk("t1_step_hi", cpu_step, 1);
    cyc(1);
    chk("t1_step_lo", cpu_step, 0);
    cyc(1);
    done_pulse();
    chk("t1_state_idle", int'(dut.state), int'(IDLE));
    chk("t1_backlog", dut.backlog, 0);

    // 2: five ticks with the CPU busy, then drain
    for (int i = 0; i < 5; i++) begin
      cpu_tick();
      if (i == 3) chk("t2_ovr_before", overrun, 0);
      cyc(1);
    end
    chk("t2_backlog3", dut.backlog, 3);
    chk("t2_ovr_set", overrun, 1);
    for (int j = 0; j < 3; j++) begin
      done_pulse();
      chk("t2_b2b_step", cpu_step, 1);
      chk("t2_backlog", dut.backlog, 2 - j);
      cyc(1);
    end
    chk("t2_ovr_sticky", overrun, 1);
    done_pulse();
    chk("t2_idle", int'(dut.state), int'(IDLE));

    // 3: ST countdown and sound
    wr_data = 8'd2; st_we = 1'b1; cyc(1); st_we = 1'b0;
    chk("t3_st2", st_value, 2);
    chk("t3_snd2", sound_on, 1);
    hz_tick();
    chk("t3_st1", st_value, 1);
    chk("t3_snd1", sound_on, 1);
    cyc(1);
    hz_tick();
    chk("t3_st0", st_value, 0);
    chk("t3_snd0", sound_on, 0);
    hz_tick();
    chk("t3_nowrap", st_value, 0);

    // 4: load beats tick; simultaneous loads
    wr_data = 8'd5; dt_we = 1'b1; cyc(1); dt_we = 1'b0;
    chk("t4_dt5", dt_value, 5);
    wr_data = 8'd9; dt_we = 1'b1; timer_60hz_tick = 1'b1;
    cyc(1);
    dt_we = 1'b0; timer_60hz_tick = 1'b0;
    chk("t4_dt9", dt_value, 9);
    wr_data = 8'd3; dt_we = 1'b1; st_we = 1'b1; cyc(1);
    dt_we = 1'b0; st_we = 1'b0;
    chk("t4_both_dt", dt_value, 3);
    chk("t4_both_st", st_value, 3);

    // 5: pause freezes issue and countdown
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("t5_ovr_clr", overrun, 0);
    wr_data = 8'd7; dt_we = 1'b1; cyc(1); dt_we = 1'b0;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin cpu_tick(); cyc(1); end
    for (int i = 0; i < 2; i++) begin hz_tick(); cyc(1); end
    chk("t5_dt7", dt_value, 7);
    chk("t5_backlog0", dut.backlog, 0);
    chk("t5_ovr0", overrun, 0);
    chk("t5_no_step", cpu_step, 0);
    pause = 1'b0;
    cyc(1);
    cpu_tick();
    chk("t5_step_after", cpu_step, 1);
    cyc(1);
    done_pulse();

    // 6: reset mid-WAIT, stale done ignored
    cpu_tick();
    cyc(1);
    cpu_tick(); cyc(1); cpu_tick();
    chk("t6_backlog2", dut.backlog, 2);
    chk("t6_wait", int'(dut.state), int'(WAIT));
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("t6_state", int'(dut.state), int'(IDLE));
    chk("t6_backlog0", dut.backlog, 0);
    chk("t6_dt0", dt_value, 0);
    chk("t6_sound0", sound_on, 0);
    done_pulse();
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_step", cpu_step, 0);
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
